button_switch_conditioner: RTL and testbench

- Front-end input conditioning stage that sits directly upstream of holiday_lights.
- Takes the raw, asynchronous, bouncing pushbutton and 3-bit slide switch from the board.
- Produces a single-cycle press pulse (drives holiday_lights.button) and a debounced, synchronised switch value (drives holiday_lights.switch).
- Both paths have identical latency, so a switch change made together with a press arrives with the pulse.

---
 rtl/button_switch_conditioner.sv | 161 ++++++++++++++++
 tb/tb_button_switch_conditioner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_switch_conditioner.sv
// Input conditioning for a bouncing pushbutton and 3-bit slide switch: synchronises both, debounces
// them with matched latency, and emits a one-cycle press pulse plus a clean switch value.
module button_switch_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_raw,
  input  logic [2:0] switch_raw,
  output logic       button_pulse,
  output logic       button_level,
  output logic [2:0] switch_out
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } btn_state_e;

  // Synchronisers: the raw pins land directly on the first flop of each chain.
  logic [SYNC_STAGES-1:0]      btn_sync_q;
  logic [SYNC_STAGES-1:0][2:0] sw_sync_q;
  logic                        btn_s;
  logic [2:0]                  sw_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_q <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], button_raw};
      sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], switch_raw};
    end
  end

  assign btn_s = btn_sync_q[SYNC_STAGES-1];
  assign sw_s  = sw_sync_q[SYNC_STAGES-1];

  // Button debounce FSM
  btn_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;
  logic            pulse_q;
  logic            level_q;

  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q != CntMax) begin
      cnt_inc = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (btn_s) begin
            cnt_q <= CntOne;
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= StPressed;
              pulse_q <= 1'b1;
              level_q <= 1'b1;
            end else begin
              state_q <= StPressWait;
            end
          end
        end
        StPressWait: begin
          if (!btn_s) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == CntMax) begin
              state_q <= StPressed;
              pulse_q <= 1'b1;
              level_q <= 1'b1;
            end
          end
        end
        StPressed: begin
          if (!btn_s) begin
            cnt_q <= CntOne;
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= StIdle;
              level_q <= 1'b0;
            end else begin
              state_q <= StReleaseWait;
            end
          end
        end
        StReleaseWait: begin
          // A bounce back high resumes the held state without a second pulse.
          if (btn_s) begin
            state_q <= StPressed;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == CntMax) begin
              state_q <= StIdle;
              level_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign button_pulse = pulse_q;
  assign button_level = level_q;

  // Switch debounce: one candidate and counter for the whole vector, so switch_out only ever
  // takes a value that was stable on all bits at once.
  logic [2:0]      cand_q;
  logic [CntW-1:0] scnt_q;
  logic [2:0]      sw_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= '0;
      scnt_q   <= CntMax;
      sw_out_q <= '0;
    end else if (sw_s != cand_q) begin
      cand_q <= sw_s;
      scnt_q <= CntOne;
      if (DEBOUNCE_CYCLES == 1) begin
        sw_out_q <= sw_s;
      end
    end else if (scnt_q != CntMax) begin
      scnt_q <= scnt_q + CntOne;
      if (scnt_q + CntOne == CntMax) begin
        sw_out_q <= cand_q;
      end
    end
  end

  assign switch_out = sw_out_q;

endmodule

// File: tb/tb_button_switch_conditioner.sv
// Bench for button_switch_conditioner: directed scenarios plus random bouncing, checked every
// cycle against a history-based model of "N identical synchronised samples flip the level".
module tb_button_switch_conditioner;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned Debounce   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button_raw = 1'b0;
  logic [2:0] switch_raw = 3'd0;
  logic       button_pulse;
  logic       button_level;
  logic [2:0] switch_out;

  button_switch_conditioner #(
    .SYNC_STAGES    (SyncStages),
    .DEBOUNCE_CYCLES(Debounce)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .button_raw  (button_raw),
    .switch_raw  (switch_raw),
    .button_pulse(button_pulse),
    .button_level(button_level),
    .switch_out  (switch_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw inputs seen at each edge since reset, delayed by the synchroniser depth.
  logic [3:0] rawq[$];
  logic [3:0] seenq[$];
  logic       m_level;
  logic       m_pulse;
  logic [2:0] m_sw;

  task automatic model_reset();
    rawq.delete();
    seenq.delete();
    m_level = 1'b0;
    m_pulse = 1'b0;
    m_sw    = 3'd0;
  endtask

  task automatic model_edge();
    int         idx;
    logic [3:0] seen;
    logic       all_opp;
    logic       all_same;
    logic [3:0] s;
    rawq.push_back({button_raw, switch_raw});
    idx  = rawq.size() - 1 - int'(SyncStages);
    seen = (idx >= 0) ? rawq[idx] : 4'd0;
    seenq.push_back(seen);
    m_pulse = 1'b0;
    if (seenq.size() >= int'(Debounce)) begin
      all_opp  = 1'b1;
      all_same = 1'b1;
      for (int k = 1; k <= int'(Debounce); k++) begin
        s = seenq[seenq.size() - k];
        if (s[3] == m_level) all_opp = 1'b0;
        if (s[2:0] != seen[2:0]) all_same = 1'b0;
      end
      if (all_opp) begin
        m_level = ~m_level;
        m_pulse = m_level;
      end
      if (all_same) m_sw = seen[2:0];
    end
  endtask

  // One clock: update model on the edge, compare at the following negedge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) model_edge();
    @(negedge clk);
    check_eq("pulse", button_pulse, m_pulse);
    check_eq("level", button_level, m_level);
    check_eq("switch", switch_out, m_sw);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Steps until a pulse is seen; returns the edge index (1-based) or -1 if none within the budget.
  task automatic wait_pulse(input int budget, output int edge_no);
    edge_no = -1;
    for (int e = 1; e <= budget; e++) begin
      step();
      if (button_pulse === 1'b1) begin
        edge_no = e;
        break;
      end
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_pulse"}, button_pulse, 0);
    check_eq({tag, "_level"}, button_level, 0);
    check_eq({tag, "_switch"}, switch_out, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    int first;
    int e;
    int bhold;
    int shold;

    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_pulse", button_pulse, 0);
    check_eq("rst_level", button_level, 0);
    check_eq("rst_switch", switch_out, 0);
    rst_n = 1'b1;

    // Clean press held 100 cycles: one pulse, SyncStages+Debounce edges in.
    button_raw = 1'b1;
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (button_pulse === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    check_eq("press_latency", first, SyncStages + Debounce);
    check_eq("press_count", pulses, 1);
    button_raw = 1'b0;
    steps(40);

    // Bounce every 5 cycles, then settle high.
    for (int i = 0; i < 60; i++) begin
      button_raw = ((i / 5) % 2) == 0;
      step();
    end
    button_raw = 1'b1;
    wait_pulse(60, e);
    check_eq("bounce_latency", e, SyncStages + Debounce);
    steps(10);

    // Release glitch while held, then full release and re-press.
    button_raw = 1'b0;
    steps(8);
    button_raw = 1'b1;
    steps(30);
    check_eq("glitch_level", button_level, 1);
    button_raw = 1'b0;
    steps(30);
    button_raw = 1'b1;
    wait_pulse(60, e);
    check_eq("repress_latency", e, SyncStages + Debounce);
    steps(5);
    button_raw = 1'b0;
    steps(30);

    // Switch 0->5 with a short excursion to 7.
    switch_raw = 3'd5;
    steps(6);
    switch_raw = 3'd7;
    steps(3);
    switch_raw = 3'd5;
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (switch_out === 3'd5 && first < 0) first = i;
    end
    check_eq("switch_latency", first, SyncStages + Debounce);

    // Simultaneous switch and press.
    switch_raw = 3'd3;
    button_raw = 1'b1;
    wait_pulse(60, e);
    check_eq("simul_latency", e, SyncStages + Debounce);
    check_eq("simul_switch", switch_out, 3);
    steps(5);
    button_raw = 1'b0;
    steps(30);

    // Random bouncing on both inputs.
    bhold = 0;
    shold = 0;
    for (int i = 0; i < 2000; i++) begin
      if (bhold == 0) begin
        button_raw = 1'($urandom_range(0, 1));
        bhold = $urandom_range(1, 26);
      end
      if (shold == 0) begin
        switch_raw = 3'($urandom_range(0, 7));
        shold = $urandom_range(1, 26);
      end
      bhold--;
      shold--;
      step();
    end

    // Reset while held with a nonzero switch value.
    button_raw = 1'b1;
    switch_raw = 3'd6;
    steps(30);
    check_eq("held_level", button_level, 1);
    check_eq("held_switch", switch_out, 6);
    async_reset_check("rst_held");
    button_raw = 1'b0;
    switch_raw = 3'd0;
    steps(30);

    // Reset mid press-debounce, then a fresh full press is needed.
    button_raw = 1'b1;
    steps(12);
    async_reset_check("rst_mid");
    wait_pulse(60, e);
    check_eq("post_rst_latency", e, SyncStages + Debounce);
    button_raw = 1'b0;
    steps(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
